// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, load funct3 encodings and writeback FSM states
package riscv_pkg;

  localparam int RISC_V_DATA_WIDTH           = 32;
  localparam int REGISTER_FILE_ADDRESS_WIDTH = 5;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_extractor.sv
// rtl/load_extractor.sv - selects the byte/halfword/word of a load response and extends it
module load_extractor
  import riscv_pkg::*;
(
  input  logic [2:0]                   funct3,
  input  logic [1:0]                   addr_lo,
  input  logic [RISC_V_DATA_WIDTH-1:0] word,
  output logic [RISC_V_DATA_WIDTH-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  // addr_lo[0] is deliberately unused for halfwords; misaligned halves are not split
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    ext_data = word;
    case (funct3)
      LB:      ext_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     ext_data = {24'd0, byte_sel};
      LH:      ext_data = {{16{half_sel[15]}}, half_sel};
      LHU:     ext_data = {16'd0, half_sel};
      default: ext_data = word;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - retire ALU results and pending loads into the register file write port
// Optional perf counters are enabled by defining WRITEBACK_PERF_CNT_EN.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ex_valid,
  output logic                                   ex_ready,
  input  logic                                   ex_is_load,
  input  logic                                   ex_wb_en,
  input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] ex_rd,
  input  logic [RISC_V_DATA_WIDTH-1:0]           ex_result,
  input  logic [2:0]                             ex_funct3,
  input  logic [1:0]                             ex_addr_lo,
  input  logic                                   mem_rsp_valid,
  input  logic [RISC_V_DATA_WIDTH-1:0]           mem_rsp_data,
  output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_num_w,
  output logic [RISC_V_DATA_WIDTH-1:0]           w_data,
  output logic                                   ctrl_reg_w,
  output logic                                   pend_valid,
  output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] pend_rd,
  output logic                                   load_timeout
`ifdef WRITEBACK_PERF_CNT_EN
  ,
  output logic [31:0]                            perf_wr_count,
  output logic [31:0]                            perf_stall_count
`endif
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(LOAD_TIMEOUT);

  wb_state_t                              state_q, state_d;
  logic [7:0]                             cnt_q, cnt_d;
  logic [7:0]                             cnt_inc;
  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] pend_rd_q, pend_rd_d;
  logic                                   pend_wb_en_q, pend_wb_en_d;
  logic [2:0]                             pend_funct3_q, pend_funct3_d;
  logic [1:0]                             pend_addr_lo_q, pend_addr_lo_d;
  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_num_w_q, reg_num_w_d;
  logic [RISC_V_DATA_WIDTH-1:0]           w_data_q, w_data_d;
  logic                                   ctrl_reg_w_q, ctrl_reg_w_d;
  logic                                   load_timeout_q, load_timeout_d;
  logic [RISC_V_DATA_WIDTH-1:0]           ext_data;

  load_extractor u_load_extractor (
    .funct3   (pend_funct3_q),
    .addr_lo  (pend_addr_lo_q),
    .word     (mem_rsp_data),
    .ext_data (ext_data)
  );

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_rd_d      = pend_rd_q;
    pend_wb_en_d   = pend_wb_en_q;
    pend_funct3_d  = pend_funct3_q;
    pend_addr_lo_d = pend_addr_lo_q;
    reg_num_w_d    = reg_num_w_q;
    w_data_d       = w_data_q;
    ctrl_reg_w_d   = 1'b0;
    load_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (ex_is_load) begin
            pend_rd_d      = ex_rd;
            pend_wb_en_d   = ex_wb_en;
            pend_funct3_d  = ex_funct3;
            pend_addr_lo_d = ex_addr_lo;
            cnt_d          = 8'd0;
            state_d        = WAIT_LOAD;
          end else begin
            reg_num_w_d  = ex_rd;
            w_data_d     = ex_result;
            ctrl_reg_w_d = ex_wb_en && (ex_rd != '0);
          end
        end
      end
      WAIT_LOAD: begin
        // A response on the limit cycle takes priority over the timeout
        if (mem_rsp_valid) begin
          reg_num_w_d  = pend_rd_q;
          w_data_d     = ext_data;
          ctrl_reg_w_d = pend_wb_en_q && (pend_rd_q != '0);
          state_d      = IDLE;
        end else if (cnt_inc == TIMEOUT_LIMIT) begin
          cnt_d          = cnt_inc;
          load_timeout_d = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      pend_rd_q      <= '0;
      pend_wb_en_q   <= 1'b0;
      pend_funct3_q  <= 3'd0;
      pend_addr_lo_q <= 2'd0;
      reg_num_w_q    <= '0;
      w_data_q       <= '0;
      ctrl_reg_w_q   <= 1'b0;
      load_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_rd_q      <= pend_rd_d;
      pend_wb_en_q   <= pend_wb_en_d;
      pend_funct3_q  <= pend_funct3_d;
      pend_addr_lo_q <= pend_addr_lo_d;
      reg_num_w_q    <= reg_num_w_d;
      w_data_q       <= w_data_d;
      ctrl_reg_w_q   <= ctrl_reg_w_d;
      load_timeout_q <= load_timeout_d;
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign pend_valid   = (state_q == WAIT_LOAD);
  assign pend_rd      = (state_q == WAIT_LOAD) ? pend_rd_q : '0;
  assign reg_num_w    = reg_num_w_q;
  assign w_data       = w_data_q;
  assign ctrl_reg_w   = ctrl_reg_w_q;
  assign load_timeout = load_timeout_q;

`ifdef WRITEBACK_PERF_CNT_EN
  logic [31:0] perf_wr_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_wr_q    <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_wr_q    <= perf_wr_q + {31'd0, ctrl_reg_w_q};
      perf_stall_q <= perf_stall_q + {31'd0, (state_q == WAIT_LOAD)};
    end
  end

  assign perf_wr_count    = perf_wr_q;
  assign perf_stall_count = perf_stall_q;
`endif

endmodule
